mc_ctrl_fsm: RTL and testbench

Parametrised multi-cycle control unit for the lab CPU. It sequences fetch, decode, execute, memory and writeback for a MIPS subset. Unlike the fixed-latency controller, it waits on a variable-latency memory handshake, traps illegal opcodes and counts retired instructions. It sits between the instruction register/ALU flags and the datapath muxes; current_state is exported for bench visibility.

---
 rtl/mc_ctrl_fsm.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multi-cycle control unit for the lab CPU (MIPS subset).
//
// Sequences fetch / decode / execute / memory / writeback. It waits on a
// variable-latency memory handshake, traps illegal opcodes and counts
// retired instructions.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Defined   : a wait counter bounds how long IF, MEM_RD and MEM_WR wait on
//               mem_ready. TIMEOUT_CYCLES consecutive low cycles send the
//               FSM to TRAP.
//   Undefined : memory waits are unbounded and no counter exists.
//
// Parameters:
//   CNT_W           width of the retired-instruction counter
//   TIMEOUT_CYCLES  max mem_ready wait cycles (only with MEM_TIMEOUT_EN)
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   opcode, funct   IR[31:26], IR[5:0] (IR holds them after fetch)
//   res_zero        ALU zero flag for the current-cycle ALU result
//   mem_ready       memory completes the access this cycle
//   current_state   state encoding, exported for visibility
//   pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
//   reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op : datapath controls
//   instr_done      one-cycle pulse, the cycle after a retiring state
//   illegal         sticky trap flag
//   instr_cnt       retired-instruction count, wraps modulo 2^CNT_W
module mc_ctrl_fsm #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             res_zero,
  input  logic             mem_ready,
  output logic [4:0]       current_state,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [4:0] {
    S_INIT    = 5'd0,
    S_IF      = 5'd1,
    S_ID      = 5'd2,
    S_EX_R    = 5'd3,
    S_EX_I    = 5'd4,
    S_EX_ADDR = 5'd5,
    S_EX_BR   = 5'd6,
    S_EX_J    = 5'd7,
    S_MEM_RD  = 5'd8,
    S_MEM_WR  = 5'd9,
    S_WB_R    = 5'd10,
    S_WB_I    = 5'd11,
    S_WB_LD   = 5'd12,
    S_HALT    = 5'd13,
    S_TRAP    = 5'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  state_t state;
  state_t next_state;
  logic   retire;
  logic   wait_expired;

  // Supported R-type funct codes; anything else traps in ID.
  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: funct_ok = 1'b1;
      default:                           funct_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] funct_alu_op(input logic [5:0] f);
    case (f)
      6'h22:   funct_alu_op = ALU_SUB;
      6'h24:   funct_alu_op = ALU_AND;
      6'h25:   funct_alu_op = ALU_OR;
      6'h2A:   funct_alu_op = ALU_SLT;
      default: funct_alu_op = ALU_ADD;
    endcase
  endfunction

  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_alu_op = ALU_AND;
      OP_ORI:  imm_alu_op = ALU_OR;
      default: imm_alu_op = ALU_ADD;
    endcase
  endfunction

  assign current_state = state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= next_state;
  end

  // Retirement and trap bookkeeping: the pulse and the count move at the
  // same edge, so instr_done is seen in the cycle after the retiring state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_done <= 1'b0;
      instr_cnt  <= '0;
      illegal    <= 1'b0;
    end else begin
      instr_done <= retire;
      if (retire)               instr_cnt <= instr_cnt + CNT_W'(1);
      if (next_state == S_TRAP) illegal   <= 1'b1;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_state;

  assign wait_state   = (state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // Last permitted low cycle: the next edge leaves for TRAP instead.
  assign wait_expired = wait_state && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          wait_cnt <= '0;
    else if (next_state != state)     wait_cnt <= '0;
    else if (wait_state && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
  end
`else
  assign wait_expired = 1'b0;
`endif

  // Next-state and output decode
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = ALU_ADD;

    case (state)
      S_INIT: next_state = S_IF;

      S_IF: begin
        iord      = 1'b0;
        mem_read  = 1'b1;
        alu_src_a = 1'b0;
        alu_src_b = 2'd1;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_src     = 2'd0;
          next_state = S_ID;
        end else if (wait_expired) begin
          next_state = S_TRAP;
        end
      end

      S_ID: begin
        // Branch target is precomputed here into ALUOut.
        alu_src_a = 1'b0;
        alu_src_b = 2'd3;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE:                next_state = funct_ok(funct) ? S_EX_R : S_TRAP;
          OP_ADDI, OP_ANDI, OP_ORI: next_state = S_EX_I;
          OP_LW, OP_SW:            next_state = S_EX_ADDR;
          OP_BEQ, OP_BNE:          next_state = S_EX_BR;
          OP_J:                    next_state = S_EX_J;
          OP_HALT:                 next_state = S_HALT;
          default:                 next_state = S_TRAP;
        endcase
      end

      S_EX_R: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd0;
        alu_op     = funct_alu_op(funct);
        next_state = S_WB_R;
      end

      S_EX_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        alu_op     = imm_alu_op(opcode);
        next_state = S_WB_I;
      end

      S_EX_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        alu_op     = ALU_ADD;
        next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_EX_BR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd0;
        alu_op     = ALU_SUB;
        pc_src     = 2'd1;
        pc_write   = ((opcode == OP_BEQ) && res_zero) ||
                     ((opcode == OP_BNE) && !res_zero);
        retire     = 1'b1;
        next_state = S_IF;
      end

      S_EX_J: begin
        pc_write   = 1'b1;
        pc_src     = 2'd2;
        retire     = 1'b1;
        next_state = S_IF;
      end

      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready)         next_state = S_WB_LD;
        else if (wait_expired) next_state = S_TRAP;
      end

      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = S_IF;
        end else if (wait_expired) begin
          next_state = S_TRAP;
        end
      end

      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        mem_to_reg = 1'b0;
        retire     = 1'b1;
        next_state = S_IF;
      end

      S_WB_I: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b1;
        next_state = S_IF;
      end

      S_WB_LD: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        next_state = S_IF;
      end

      S_HALT:  next_state = S_HALT;
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed testbench for mc_ctrl_fsm (CNT_W=4 so counter wrap is reachable).
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       res_zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [4:0] current_state;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       instr_done;
  logic       illegal;
  logic [3:0] instr_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mc_ctrl_fsm #(.CNT_W(4), .TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct         (funct),
    .res_zero      (res_zero),
    .mem_ready     (mem_ready),
    .current_state (current_state),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .illegal       (illegal),
    .instr_cnt     (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Synchronously-timed pulse of the async reset; leaves the FSM in INIT.
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // ---- 1: add ----
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    do_reset();
    chk("rst_state", 32'(current_state), 0);
    chk("rst_cnt", 32'(instr_cnt), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_done", 32'(instr_done), 0);
    chk("init_mem_read", 32'(mem_read), 0);
    step(); chk("add_if", 32'(current_state), 1);
    chk("add_if_irw", 32'(ir_write), 1);
    chk("add_if_pcw", 32'(pc_write), 1);
    chk("add_if_srcb", 32'(alu_src_b), 1);
    step(); chk("add_id", 32'(current_state), 2);
    chk("add_id_srcb", 32'(alu_src_b), 3);
    step(); chk("add_ex", 32'(current_state), 3);
    chk("add_ex_srca", 32'(alu_src_a), 1);
    chk("add_ex_op", 32'(alu_op), 0);
    step(); chk("add_wb", 32'(current_state), 10);
    chk("add_wb_rw", 32'(reg_write), 1);
    chk("add_wb_dst", 32'(reg_dst), 1);
    chk("add_wb_done", 32'(instr_done), 0);
    step(); chk("add_ret_state", 32'(current_state), 1);
    chk("add_done", 32'(instr_done), 1);
    chk("add_cnt", 32'(instr_cnt), 1);
    step(); chk("add_done_clr", 32'(instr_done), 0);

    // ---- sub/slt alu_op from funct ----
    funct = 6'h2A;
    do_reset(); step(); step(); step();
    chk("slt_op", 32'(alu_op), 4);

    // ---- 2: lw with 3 wait cycles ----
    opcode = 6'h23; mem_ready = 1'b1;
    do_reset();
    step(); chk("lw_if", 32'(current_state), 1);
    step(); chk("lw_id", 32'(current_state), 2);
    step(); chk("lw_exa", 32'(current_state), 5);
    chk("lw_exa_srcb", 32'(alu_src_b), 2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lw_wait_state", 32'(current_state), 8);
      chk("lw_wait_rd", 32'(mem_read), 1);
      chk("lw_wait_iord", 32'(iord), 1);
    end
    mem_ready = 1'b1;
    #1 chk("lw_rdy_state", 32'(current_state), 8);
    step(); chk("lw_wb", 32'(current_state), 12);
    chk("lw_wb_m2r", 32'(mem_to_reg), 1);
    chk("lw_wb_rw", 32'(reg_write), 1);
    step(); chk("lw_done", 32'(instr_done), 1);
    chk("lw_cnt", 32'(instr_cnt), 1);

    // ---- sw ----
    opcode = 6'h2B;
    do_reset(); step(); step(); step();
    step(); chk("sw_state", 32'(current_state), 9);
    chk("sw_wr", 32'(mem_write), 1);
    chk("sw_rd", 32'(mem_read), 0);
    step(); chk("sw_done", 32'(instr_done), 1);
    chk("sw_back_if", 32'(current_state), 1);

    // ---- ori ----
    opcode = 6'h0D;
    do_reset(); step(); step();
    step(); chk("ori_ex", 32'(current_state), 4);
    chk("ori_op", 32'(alu_op), 3);
    step(); chk("ori_wb", 32'(current_state), 11);
    chk("ori_dst", 32'(reg_dst), 0);
    chk("ori_rw", 32'(reg_write), 1);

    // ---- 3: beq taken / not taken, bne ----
    opcode = 6'h04; res_zero = 1'b1;
    do_reset(); step(); step();
    step(); chk("beq1_state", 32'(current_state), 6);
    chk("beq1_pcw", 32'(pc_write), 1);
    chk("beq1_src", 32'(pc_src), 1);
    chk("beq1_op", 32'(alu_op), 1);
    res_zero = 1'b0;
    #1 chk("beq0_pcw_comb", 32'(pc_write), 0);
    step(); chk("beq1_done", 32'(instr_done), 1);
    step(); step(); chk("beq0_state", 32'(current_state), 6);
    chk("beq0_pcw", 32'(pc_write), 0);
    opcode = 6'h05;
    #1 chk("bne_pcw", 32'(pc_write), 1);
    step(); chk("beq0_done", 32'(instr_done), 1);
    chk("br_cnt", 32'(instr_cnt), 2);

    // ---- 4: illegal funct ----
    opcode = 6'h00; funct = 6'h03;
    do_reset(); step(); step();
    step(); chk("trap_state", 32'(current_state), 14);
    chk("trap_illegal", 32'(illegal), 1);
    step(); step();
    chk("trap_sticky", 32'(illegal), 1);
    chk("trap_hold", 32'(current_state), 14);
    chk("trap_cnt", 32'(instr_cnt), 0);
    chk("trap_done", 32'(instr_done), 0);
    rst = 1'b1;
    #1 chk("trap_rst_state", 32'(current_state), 0);
    chk("trap_rst_illegal", 32'(illegal), 0);
    step(); rst = 1'b0;

    // ---- 5: 16 jumps wrap the 4-bit counter, then halt ----
    opcode = 6'h02; funct = 6'h00;
    do_reset(); step();
    for (int i = 0; i < 16; i++) begin
      step();
      step(); chk("j_state", 32'(current_state), 7);
      chk("j_pcw", 32'(pc_write), 1);
      chk("j_src", 32'(pc_src), 2);
      step(); chk("j_done", 32'(instr_done), 1);
      chk("j_cnt", 32'(instr_cnt), 32'((i + 1) % 16));
    end
    chk("j_wrap", 32'(instr_cnt), 0);
    opcode = 6'h3F;
    step(); step(); chk("halt_state", 32'(current_state), 13);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_hold", 32'(current_state), 13);
      chk("halt_nodone", 32'(instr_done), 0);
      chk("halt_mem_read", 32'(mem_read), 0);
    end
    chk("halt_cnt", 32'(instr_cnt), 0);

    // ---- 6: fetch wait with mem_ready low ----
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b0;
    do_reset(); step();
    chk("wait_if", 32'(current_state), 1);
    chk("wait_irw", 32'(ir_write), 0);
    for (int i = 0; i < 15; i++) step();
    chk("wait_16", 32'(current_state), 1);
    step();
`ifdef MEM_TIMEOUT_EN
    chk("timeout_trap", 32'(current_state), 14);
    chk("timeout_illegal", 32'(illegal), 1);
`else
    chk("no_timeout", 32'(current_state), 1);
    chk("no_timeout_illegal", 32'(illegal), 0);
`endif
    do_reset(); step();
    for (int i = 0; i < 5; i++) step();
    chk("midwait_if", 32'(current_state), 1);
    rst = 1'b1;
    #1 chk("midwait_rst", 32'(current_state), 0);
    step(); rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
